// File: rtl/mult_rom_reader.sv
// Read-side initiator for the multiplication lookup ROM: single operand-pair lookups
// over valid/ready, plus a full-address self-check sweep against a*b.
module mult_rom_reader #(
    parameter int unsigned N      = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N/2-1:0]   in_a,
    input  logic [N/2-1:0]   in_b,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_product,
    input  logic             out_ready,
    output logic [N-1:0]     rom_address,
    output logic             rom_ce,
    output logic             rom_read_en,
    input  logic [N-1:0]     rom_data,
    input  logic             start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [N:0]       err_count,
    output logic [N-1:0]     first_err_addr
);

    localparam int unsigned H     = N / 2;
    localparam int unsigned CNT_W = N + 1;
    localparam int unsigned WC_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [N-1:0]     addr;
    logic [N-1:0]     addr_d;
    logic [WC_W-1:0]  wcnt;
    logic [WC_W-1:0]  wcnt_d;

    logic             in_ready_d;
    logic             out_valid_d;
    logic [N-1:0]     out_product_d;
    logic [N-1:0]     rom_address_d;
    logic             rom_ce_d;
    logic             sweep_busy_d;
    logic             sweep_done_d;
    logic [N:0]       err_count_d;
    logic [N-1:0]     first_err_addr_d;

    logic             accept_start;
    logic             accept_op;
    logic             sample;
    logic             last_addr;
    logic             mismatch;
    logic [N-1:0]     expect_prod;

    // start wins over in_valid; neither is taken until in_ready is up
    assign accept_start = (state == IDLE) && in_ready && start;
    assign accept_op    = (state == IDLE) && in_ready && !start && in_valid;

    // rom_data is valid on the edge ending ISSUE (RD_LAT=0) or the last WAIT cycle
    assign sample = ((RD_LAT == 0) && (state == ISSUE)) ||
                    ((state == WAIT) && ((32'(wcnt) + 32'd1) == RD_LAT));

    assign last_addr   = (addr == {N{1'b1}});
    assign expect_prod = N'(addr[N-1:H]) * N'(addr[H-1:0]);
    assign mismatch    = (rom_data != expect_prod);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_start || accept_op) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (RD_LAT != 0) begin
                    state_nx = WAIT;
                end else if (!sweep_busy) begin
                    state_nx = RESP;
                end else if (last_addr) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = ISSUE;
                end
            end
            WAIT: begin
                if (sample) begin
                    if (!sweep_busy) begin
                        state_nx = RESP;
                    end else if (last_addr) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            RESP: begin
                if (out_valid && out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        addr_d           = addr;
        wcnt_d           = '0;
        in_ready_d       = 1'b0;
        out_valid_d      = out_valid;
        out_product_d    = out_product;
        rom_address_d    = '0;
        rom_ce_d         = 1'b0;
        sweep_busy_d     = sweep_busy;
        sweep_done_d     = 1'b0;
        err_count_d      = err_count;
        first_err_addr_d = first_err_addr;

        if (accept_start) begin
            sweep_busy_d     = 1'b1;
            err_count_d      = '0;
            first_err_addr_d = '0;
            addr_d           = '0;
        end else if (accept_op) begin
            addr_d = {in_a, in_b};
        end

        if (state == WAIT) begin
            wcnt_d = wcnt + WC_W'(1);
        end

        if (sample) begin
            if (sweep_busy) begin
                if (mismatch) begin
                    err_count_d = err_count + CNT_W'(1);
                    if (err_count == '0) begin
                        first_err_addr_d = addr;
                    end
                end
                if (last_addr) begin
                    sweep_busy_d = 1'b0;
                    sweep_done_d = 1'b1;
                end else begin
                    addr_d = addr + N'(1);
                end
            end else begin
                out_valid_d   = 1'b1;
                out_product_d = rom_data;
            end
        end

        if ((state == RESP) && out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_nx == IDLE);

        // ROM pins are only non-zero during the single ISSUE cycle
        if (state_nx == ISSUE) begin
            rom_ce_d      = 1'b1;
            rom_address_d = addr_d;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr           <= '0;
            wcnt           <= '0;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            out_product    <= '0;
            rom_address    <= '0;
            rom_ce         <= 1'b0;
            rom_read_en    <= 1'b0;
            sweep_busy     <= 1'b0;
            sweep_done     <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            addr           <= addr_d;
            wcnt           <= wcnt_d;
            in_ready       <= in_ready_d;
            out_valid      <= out_valid_d;
            out_product    <= out_product_d;
            rom_address    <= rom_address_d;
            rom_ce         <= rom_ce_d;
            rom_read_en    <= rom_ce_d;
            sweep_busy     <= sweep_busy_d;
            sweep_done     <= sweep_done_d;
            err_count      <= err_count_d;
            first_err_addr <= first_err_addr_d;
        end
    end

endmodule

// File: tb/tb_mult_rom_reader.sv
// Directed bench for mult_rom_reader with N=8, RD_LAT=1 and a registered ROM model.
module tb_mult_rom_reader;

    localparam int unsigned N      = 8;
    localparam int unsigned RD_LAT = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [3:0]   in_a = '0;
    logic [3:0]   in_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_product;
    logic         out_ready = 1'b0;
    logic [7:0]   rom_address;
    logic         rom_ce;
    logic         rom_read_en;
    logic [7:0]   rom_data;
    logic         start = 1'b0;
    logic         sweep_busy;
    logic         sweep_done;
    logic [8:0]   err_count;
    logic [7:0]   first_err_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [256];
    logic [7:0] rom_q = '0;

    always #5 clk = ~clk;

    // One-cycle-latency ROM
    always @(posedge clk) begin
        if (rom_ce && rom_read_en) rom_q <= rom[rom_address];
    end
    assign rom_data = rom_q;

    mult_rom_reader #(.N(N), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .out_valid(out_valid), .out_product(out_product), .out_ready(out_ready),
        .rom_address(rom_address), .rom_ce(rom_ce), .rom_read_en(rom_read_en),
        .rom_data(rom_data),
        .start(start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        logic       stall;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({in_ready, out_valid, out_product, rom_address, rom_ce, rom_read_en,
                    sweep_busy, sweep_done, err_count, first_err_addr});
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic txn(input vec_t v);
        wait_ready();
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        out_ready = !v.stall;
        @(negedge clk);
        in_valid = 1'b0;
        check("issue_ce", 64'({rom_ce, rom_read_en}), 64'd3);
        check("issue_addr", 64'(rom_address), 64'({v.a, v.b}));
        @(negedge clk);
        check("wait_ce", 64'({rom_ce, rom_address}), 64'd0);
        check("wait_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("resp_valid", 64'(out_valid), 64'd1);
        check("resp_product", 64'(out_product), 64'(v.p));
        if (v.stall) begin
            for (int i = 0; i < 4; i++) begin
                check("stall_hold", 64'({out_valid, out_product, in_ready, rom_ce}),
                      64'({1'b1, v.p, 1'b0, 1'b0}));
                @(negedge clk);
            end
            check("stall_release_valid", 64'({out_valid, out_product}), 64'({1'b1, v.p}));
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("after_resp", 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1'b0;
    endtask

    task automatic run_sweep(input logic with_op, input logic [8:0] exp_err, input logic [7:0] exp_first);
        int nexp = 0;
        int order_err = 0;
        int ov = 0;
        int done_at = -1;
        wait_ready();
        start    = 1'b1;
        in_valid = with_op;
        in_a     = 4'h9;
        in_b     = 4'h9;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("sweep_start_state", 64'({sweep_busy, err_count, first_err_addr}), 64'({1'b1, 9'd0, 8'd0}));
        for (int c = 0; c < 1100; c++) begin
            if (rom_ce) begin
                if (rom_address !== 8'(nexp)) order_err++;
                nexp++;
            end
            if (out_valid) ov++;
            if (sweep_done) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        check("sweep_issue_count", 64'(nexp), 64'd256);
        check("sweep_addr_order", 64'(order_err), 64'd0);
        check("sweep_done_cycle", 64'(done_at), 64'd512);
        check("sweep_no_out_valid", 64'(ov), 64'd0);
        check("sweep_err_count", 64'(err_count), 64'(exp_err));
        check("sweep_first_err", 64'(first_err_addr), 64'(exp_first));
        check("sweep_busy_clear", 64'(sweep_busy), 64'd0);
        @(negedge clk);
        check("sweep_done_pulse", 64'({sweep_done, in_ready, out_valid, rom_ce}), 64'b0100);
        check("sweep_result_hold", 64'({err_count, first_err_addr}), 64'({exp_err, exp_first}));
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) rom[i] = 8'((i >> 4) * (i & 15));

        vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F, stall: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F, stall: 1'b1};
        vecs[2] = '{a: 4'd15, b: 4'd15, p: 8'hE1, stall: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd9,  p: 8'h00, stall: 1'b0};
        vecs[4] = '{a: 4'd7,  b: 4'd8,  p: 8'h38, stall: 1'b0};
        vecs[5] = '{a: 4'd12, b: 4'd10, p: 8'h78, stall: 1'b0};
        vecs[6] = '{a: 4'd1,  b: 4'd1,  p: 8'h01, stall: 1'b0};
        vecs[7] = '{a: 4'd15, b: 4'd1,  p: 8'h0F, stall: 1'b1};

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", all_outs(), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("ready_after_release", 64'({in_ready, rom_ce, out_valid}), 64'b100);

        foreach (vecs[i]) txn(vecs[i]);

        run_sweep(1'b0, 9'd0, 8'h00);

        rom[8'h23] = rom[8'h23] ^ 8'h01;
        rom[8'hF1] = 8'h00;
        run_sweep(1'b0, 9'd2, 8'h23);
        run_sweep(1'b0, 9'd2, 8'h23);

        // start and in_valid together, then reset mid-sweep at 0x80
        wait_ready();
        start    = 1'b1;
        in_valid = 1'b1;
        in_a     = 4'h2;
        in_b     = 4'h3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_priority_busy", 64'({sweep_busy, rom_ce, rom_address}), 64'({1'b1, 1'b1, 8'h00}));
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (out_valid) check("op_not_accepted", 64'(out_valid), 64'd0);
            if (rom_ce && rom_address == 8'h80) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_0x80", 64'(found), 64'd1);
        check("pre_rst_err", 64'({err_count, first_err_addr}), 64'({9'd1, 8'h23}));
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_no_done", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_sweep(1'b0, 9'd2, 8'h23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
